// File: rtl/alu_io_pkg.sv
// rtl/alu_io_pkg.sv - shared state encoding and field widths for the ALU operand entry path
package alu_io_pkg;

  localparam int OPCODE_W  = 2;
  localparam int OPERAND_W = 4;

  // The stage output reuses this encoding directly.
  typedef enum logic [1:0] {
    ST_GET_A  = 2'd0,
    ST_GET_B  = 2'd1,
    ST_GET_OP = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser, consecutive-sample debouncer and rising-edge pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_q;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= raw;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      // The edge that completes the run of differing samples flips the level.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_level & ~r_level_q;

endmodule

// File: rtl/alu_operand_entry.sv
// rtl/alu_operand_entry.sv - board button/switch front end stepping operand A, operand B and opcode into the ALU
module alu_operand_entry
  import alu_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPERAND_W-1:0] sw,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  input  logic                 alu_ack,
  output logic [OPERAND_W-1:0] operand_a,
  output logic [OPERAND_W-1:0] operand_b,
  output logic [OPCODE_W-1:0]  opcode,
  output logic                 operands_valid,
  output logic [1:0]           stage
);

  logic w_enter_level;
  logic w_enter_press;
  logic w_clear_level;
  logic w_clear_press;
  logic w_unused;

  logic [OPERAND_W-1:0] r_sw_sync1;
  logic [OPERAND_W-1:0] r_sw_sync2;
  state_t               r_state;
  logic [OPERAND_W-1:0] r_operand_a;
  logic [OPERAND_W-1:0] r_operand_b;
  logic [OPCODE_W-1:0]  r_opcode;
  logic                 r_valid;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_enter),
    .level (w_enter_level),
    .press (w_enter_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_clear),
    .level (w_clear_level),
    .press (w_clear_press)
  );

  // Debounced levels are available for future status use; only the pulses drive the FSM.
  assign w_unused = w_enter_level ^ w_clear_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_sync1  <= '0;
      r_sw_sync2  <= '0;
      r_state     <= ST_GET_A;
      r_operand_a <= '0;
      r_operand_b <= '0;
      r_opcode    <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_sw_sync1 <= sw;
      r_sw_sync2 <= r_sw_sync1;
      if (w_clear_press) begin
        r_state     <= ST_GET_A;
        r_operand_a <= '0;
        r_operand_b <= '0;
        r_opcode    <= '0;
        r_valid     <= 1'b0;
      end else begin
        case (r_state)
          ST_GET_A: if (w_enter_press) begin
            r_operand_a <= r_sw_sync2;
            r_state     <= ST_GET_B;
          end
          ST_GET_B: if (w_enter_press) begin
            r_operand_b <= r_sw_sync2;
            r_state     <= ST_GET_OP;
          end
          ST_GET_OP: if (w_enter_press) begin
            r_opcode <= r_sw_sync2[OPCODE_W-1:0];
            r_valid  <= 1'b1;
            r_state  <= ST_DONE;
          end
          // Captured data is kept after the ack so the display still shows it.
          ST_DONE: if (alu_ack) begin
            r_valid <= 1'b0;
            r_state <= ST_GET_A;
          end
          default: r_state <= ST_GET_A;
        endcase
      end
    end
  end

  assign operand_a      = r_operand_a;
  assign operand_b      = r_operand_b;
  assign opcode         = r_opcode;
  assign operands_valid = r_valid;
  assign stage          = r_state;

endmodule

// File: tb/tb_alu_operand_entry.sv
// tb/tb_alu_operand_entry.sv - directed scoreboard bench for alu_operand_entry with a short debounce window
module tb_alu_operand_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic       alu_ack;
  logic [3:0] operand_a;
  logic [3:0] operand_b;
  logic [1:0] opcode;
  logic       operands_valid;
  logic [1:0] stage;

  always #5 clk = ~clk;

  alu_operand_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw             (sw),
    .btn_enter      (btn_enter),
    .btn_clear      (btn_clear),
    .alu_ack        (alu_ack),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .opcode         (opcode),
    .operands_valid (operands_valid),
    .stage          (stage)
  );

  typedef struct packed {
    logic [1:0] stage;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       valid;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [1:0] m_stage;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [1:0] m_op;
  logic       m_valid;

  task automatic model_clear();
    m_stage = 2'd0; m_a = 4'h0; m_b = 4'h0; m_op = 2'd0; m_valid = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.stage = m_stage; e.a = m_a; e.b = m_b; e.op = m_op; e.valid = m_valid;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      cmp(tag, "stage", {2'b00, stage}, {2'b00, e.stage});
      cmp(tag, "operand_a", operand_a, e.a);
      cmp(tag, "operand_b", operand_b, e.b);
      cmp(tag, "opcode", {2'b00, opcode}, {2'b00, e.op});
      cmp(tag, "valid", {3'b000, operands_valid}, {3'b000, e.valid});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Held long enough to debounce the press, then released long enough to debounce the release.
  task automatic press(input logic en, input logic cl);
    btn_enter = en;
    btn_clear = cl;
    tick(8);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(10);
  endtask

  task automatic set_sw(input logic [3:0] v);
    sw = v;
    tick(3);
  endtask

  initial begin
    rst_n = 1'b0; sw = 4'h0; btn_enter = 1'b0; btn_clear = 1'b0; alu_ack = 1'b0;
    model_clear();
    tick(2);
    push_exp(); check("reset");
    rst_n = 1'b1;
    tick(2);

    set_sw(4'hF);
    press(1'b1, 1'b0);
    m_a = 4'hF; m_stage = 2'd1;
    push_exp(); check("t1_get_b");
    rst_n = 1'b0;
    #1;
    model_clear();
    push_exp(); check("t1_async_reset");
    tick(2);
    rst_n = 1'b1;
    tick(3);
    push_exp(); check("t1_release");

    set_sw(4'h5);
    btn_enter = 1'b1; tick(1);
    btn_enter = 1'b0; tick(1);
    btn_enter = 1'b1; tick(1);
    btn_enter = 1'b0; tick(1);
    btn_enter = 1'b1;
    tick(6);
    push_exp(); check("t2_edge6");
    tick(1);
    m_stage = 2'd1; m_a = 4'h5;
    push_exp(); check("t2_edge7");
    tick(3);
    btn_enter = 1'b0;
    tick(12);
    push_exp(); check("t2_single_pulse");

    press(1'b0, 1'b1);
    model_clear();
    push_exp(); check("clear_in_get_b");

    set_sw(4'h9); press(1'b1, 1'b0);
    set_sw(4'h3); press(1'b1, 1'b0);
    set_sw(4'h2); press(1'b1, 1'b0);
    m_stage = 2'd3; m_a = 4'h9; m_b = 4'h3; m_op = 2'd2; m_valid = 1'b1;
    push_exp(); check("t3_done");

    tick(20);
    push_exp(); check("t4_hold_no_ack");
    set_sw(4'hE);
    press(1'b1, 1'b0);
    push_exp(); check("t4_enter_ignored");
    alu_ack = 1'b1;
    tick(1);
    alu_ack = 1'b0;
    m_stage = 2'd0; m_valid = 1'b0;
    push_exp(); check("t4_ack");
    alu_ack = 1'b1;
    tick(2);
    alu_ack = 1'b0;
    tick(1);
    push_exp(); check("t4_ack_outside_done");

    set_sw(4'h6); press(1'b1, 1'b0);
    set_sw(4'hA); press(1'b1, 1'b0);
    m_stage = 2'd2; m_a = 4'h6; m_b = 4'hA;
    push_exp(); check("t5_get_op");
    set_sw(4'h1);
    press(1'b1, 1'b1);
    model_clear();
    push_exp(); check("t5_clear_wins");

    set_sw(4'h7);
    btn_enter = 1'b1;
    tick(3);
    btn_enter = 1'b0;
    tick(12);
    push_exp(); check("t6_glitch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
